dac_serial_multich: RTL
=======================

# dac_serial_multich

Parametrised serial DAC driver for SPI-style multi-channel DACs with a 4-phase handshake to the controller. It serialises command/address/data frames MSB-first with a programmable SCK rate. A single request transfers either one channel or a sweep of all NCH channels, followed by an optional LDAC pulse so all outputs update simultaneously. It sits between the sample controller and the DAC pins, replacing the fixed 16-bit single-channel driver.

## Interface
- DATA_W, 12, data bits per channel
- ADDR_W, 4, address field width; NCH <= 2^ADDR_W
- CMD_W, 4, command field width
- NCH, 4, channel count (sweep mode frames per request)
- SCK_DIV, 1, SCK half-period in dacclk cycles (>=1)
- LDAC_EN, 1, 1: pulse dacld low after last frame; 0: dacld held 0 (per-frame update)
- LDAC_W, 2, dacld low pulse width in cycles (>=1)
- CS_GAP, 2, daccs high cycles between sweep frames (>=1)
- FRAME_W (derived), CMD_W+ADDR_W+DATA_W
- dacclk  in  1  clock; all logic on rising edge
- dacrstn  in  1  synchronous reset, active-low
- dacdav  in  1  request from controller
- davdac  out  1  acknowledge to controller
- dacmode  in  1  0 single channel, 1 sweep all channels
- dacaddr  in  ADDR_W  channel for single mode
- daccmd  in  CMD_W  command field for every frame
- dacdata  in  NCH*DATA_W  channel k data at [k*DATA_W +: DATA_W]; single mode uses [DATA_W-1:0]
- dacout  out  1  serial data (DIN)
- dacsck  out  1  serial clock
- daccs  out  1  chip select, active-low
- dacld  out  1  LDAC, active-low
- dacbusy  out  1  high from request capture until davdac rises

## Operation
- Reset (dacrstn=0 at edge, any state incl. mid-frame): daccs=1, dacsck=0, dacout=0, davdac=0, dacbusy=0, dacld=LDAC_EN?1:0, state IDLE, counters 0.
- States: IDLE, SHIFT_LO, SHIFT_HI, GAP, LDAC, ACK.
- IDLE: on dacdav=1 and davdac=0, capture dacmode, dacaddr, daccmd, dacdata into shadow registers; frame index k=0; go SHIFT_LO. Inputs may change after capture.
- Frame k = {daccmd, addr_k, data_k}; addr_k = dacaddr (single) or k (sweep); data_k = dacdata[DATA_W-1:0] (single) or channel k slice.
- SHIFT_LO: daccs=0, dacsck=0, dacout = current bit (MSB first) set on entry; hold SCK_DIV cycles; go SHIFT_HI.
- SHIFT_HI: dacsck=1 for SCK_DIV cycles; DAC samples on rising SCK. After bit 0: daccs=1, dacsck=0; if more frames go GAP, else LDAC (LDAC_EN=1) or ACK (LDAC_EN=0).
- GAP: daccs high CS_GAP cycles, k++, go SHIFT_LO.
- LDAC: dacld=0 for LDAC_W cycles, then dacld=1, go ACK.
- ACK: davdac=1, dacbusy=0; hold until dacdav=0, then davdac=0, go IDLE.
- Abort: dacdav=0 while in SHIFT_LO/SHIFT_HI/GAP/LDAC -> next edge daccs=1, dacsck=0, dacld=LDAC_EN?1:0, dacbusy=0, davdac stays 0, IDLE. Partial frame is discarded by the DAC (CS rises early).
- New request accepted only after davdac has returned to 0.

## Timing
- E0 = capture edge; daccs falls and first dacout valid at E0.
- Frame length Tf = 2*SCK_DIV*FRAME_W cycles; frame k starts at E0 + k*(Tf+CS_GAP).
- Last frame CS rise at T = E0 + (F-1)*(Tf+CS_GAP) + Tf, F = 1 (single) or NCH (sweep).
- LDAC_EN=1: dacld low at edges T+1 .. T+LDAC_W; dacld=1 and davdac=1 at T+1+LDAC_W.
- LDAC_EN=0: davdac=1 at T (same edge as CS rise).
- davdac falls on the first edge at which dacdav=0 is sampled.
- dacout changes only on SCK falling edges or at CS fall; stable for SCK_DIV cycles before and during SCK high.

## Test plan
- Reset mid-frame (defaults, sweep, dacrstn=0 at E0+10) -> next edge daccs=1, dacsck=0, dacld=1, davdac=0, dacbusy=0.
- Single, defaults, daccmd=3, dacaddr=2, data 0xABC -> 20 SCK rises sampling 0x32ABC; dacld low at E0+41..E0+42; davdac=1 at E0+43.
- Sweep NCH=4, channel data 0x111/0x222/0x333/0x444 -> frames with addr 0..3 at E0, E0+42, E0+84, E0+126; one dacld pulse; davdac at E0+169.
- SCK_DIV=3, LDAC_EN=0, single -> SCK high/low 3 cycles each, Tf=120; davdac=1 with CS rise at E0+120.
- Abort: drop dacdav at E0+15 -> daccs=1 next edge, no dacld pulse, davdac stays 0; new request then completes normally.
- Handshake: hold dacdav high 10 cycles after ack -> davdac stays 1, no retransmit; davdac=0 one edge after dacdav=0.

Source files
------------

// File: rtl/dac_serial_multich_if.sv
// Controller/DAC-pin bundle for dac_serial_multich.
// master: controller side (dacdav, mode, addr, cmd, data); slave: driver.
interface dac_serial_multich_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 4,
  parameter int CMD_W  = 4,
  parameter int NCH    = 4
);
  logic                   dacdav;
  logic                   davdac;
  logic                   dacmode;
  logic [ADDR_W-1:0]      dacaddr;
  logic [CMD_W-1:0]       daccmd;
  logic [NCH*DATA_W-1:0]  dacdata;
  logic                   dacout;
  logic                   dacsck;
  logic                   daccs;
  logic                   dacld;
  logic                   dacbusy;

  modport master (
    output dacdav, dacmode, dacaddr,
    output daccmd, dacdata,
    input  davdac, dacout, dacsck,
    input  daccs, dacld, dacbusy
  );

  modport slave (
    input  dacdav, dacmode, dacaddr,
    input  daccmd, dacdata,
    output davdac, dacout, dacsck,
    output daccs, dacld, dacbusy
  );
endinterface

// File: rtl/dac_serial_multich.sv
// Multi-channel SPI DAC driver: single/sweep frames, optional LDAC pulse.
// Ports: dacclk, dacrstn (sync, active-low), bus (slave modport).
module dac_serial_multich #(
  parameter int DATA_W  = 12,
  parameter int ADDR_W  = 4,
  parameter int CMD_W   = 4,
  parameter int NCH     = 4,
  parameter int SCK_DIV = 1,
  parameter int LDAC_EN = 1,
  parameter int LDAC_W  = 2,
  parameter int CS_GAP  = 2
) (
  input  logic                 dacclk,
  input  logic                 dacrstn,
  dac_serial_multich_if.slave  bus
);

  localparam int FRAME_W = CMD_W + ADDR_W + DATA_W;
  localparam int BW      = $clog2(FRAME_W);
  localparam logic LD_IDLE = (LDAC_EN != 0);
  localparam logic [15:0] SCK_END = 16'(SCK_DIV - 1);
  localparam logic [15:0] GAP_END = 16'(CS_GAP - 1);
  localparam logic [15:0] LD_END  = 16'(LDAC_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_W - 1);

  typedef enum logic [2:0] {
    IDLE, SHIFT_LO, SHIFT_HI, GAP, LDAC, ACK
  } state_t;

  state_t                st;
  logic                  mode_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [CMD_W-1:0]      cmd_q;
  logic [NCH*DATA_W-1:0] data_q;
  logic [ADDR_W-1:0]     k;
  logic [FRAME_W-1:0]    sr;
  logic [BW-1:0]         bitn;
  logic [15:0]           cnt;

  logic [ADDR_W-1:0]     k_nxt;
  logic [FRAME_W-1:0]    first_frame;
  logic [FRAME_W-1:0]    next_frame;
  logic                  last_frame;
  logic                  active;

  // Frame 0 is built straight from the inputs so the
  // first bit can be on dacout at the capture edge.
  always_comb begin
    k_nxt = k + 1'b1;
    first_frame = {
      bus.daccmd,
      bus.dacmode ? {ADDR_W{1'b0}} : bus.dacaddr,
      bus.dacdata[DATA_W-1:0]
    };
    next_frame = {
      cmd_q, k_nxt,
      data_q[int'(k_nxt)*DATA_W +: DATA_W]
    };
    last_frame = !mode_q || (k == ADDR_W'(NCH - 1));
    active = st inside {SHIFT_LO, SHIFT_HI, GAP, LDAC};
  end

  always_ff @(posedge dacclk) begin
    if (!dacrstn) begin
      st          <= IDLE;
      mode_q      <= 1'b0;
      addr_q      <= '0;
      cmd_q       <= '0;
      data_q      <= '0;
      k           <= '0;
      sr          <= '0;
      bitn        <= '0;
      cnt         <= '0;
      bus.daccs   <= 1'b1;
      bus.dacsck  <= 1'b0;
      bus.dacout  <= 1'b0;
      bus.davdac  <= 1'b0;
      bus.dacbusy <= 1'b0;
      bus.dacld   <= LD_IDLE;
    end else if (active && !bus.dacdav) begin
      // Abort: raising CS early makes the DAC drop the partial frame.
      st          <= IDLE;
      cnt         <= '0;
      bus.daccs   <= 1'b1;
      bus.dacsck  <= 1'b0;
      bus.dacout  <= 1'b0;
      bus.dacbusy <= 1'b0;
      bus.dacld   <= LD_IDLE;
    end else begin
      unique case (st)
        IDLE: begin
          if (bus.dacdav && !bus.davdac) begin
            mode_q      <= bus.dacmode;
            addr_q      <= bus.dacaddr;
            cmd_q       <= bus.daccmd;
            data_q      <= bus.dacdata;
            k           <= '0;
            sr          <= first_frame;
            bitn        <= '0;
            cnt         <= '0;
            bus.dacout  <= first_frame[FRAME_W-1];
            bus.daccs   <= 1'b0;
            bus.dacsck  <= 1'b0;
            bus.dacbusy <= 1'b1;
            st          <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (cnt == SCK_END) begin
            cnt        <= '0;
            bus.dacsck <= 1'b1;
            st         <= SHIFT_HI;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT_HI: begin
          if (cnt == SCK_END) begin
            cnt        <= '0;
            bus.dacsck <= 1'b0;
            if (bitn == LAST_BIT) begin
              bus.daccs  <= 1'b1;
              bus.dacout <= 1'b0;
              if (!last_frame) begin
                st <= GAP;
              end else if (LDAC_EN != 0) begin
                st <= LDAC;
              end else begin
                bus.davdac  <= 1'b1;
                bus.dacbusy <= 1'b0;
                st          <= ACK;
              end
            end else begin
              bitn       <= bitn + 1'b1;
              sr         <= sr << 1;
              bus.dacout <= sr[FRAME_W-2];
              st         <= SHIFT_LO;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_END) begin
            cnt        <= '0;
            k          <= k_nxt;
            sr         <= next_frame;
            bitn       <= '0;
            bus.dacout <= next_frame[FRAME_W-1];
            bus.daccs  <= 1'b0;
            st         <= SHIFT_LO;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LDAC: begin
          // First cycle here only arms the pulse; dacld low for LDAC_W edges.
          if (cnt == LD_END) begin
            cnt         <= '0;
            bus.dacld   <= 1'b1;
            bus.davdac  <= 1'b1;
            bus.dacbusy <= 1'b0;
            st          <= ACK;
          end else begin
            cnt       <= cnt + 1'b1;
            bus.dacld <= 1'b0;
          end
        end
        ACK: begin
          if (!bus.dacdav) begin
            bus.davdac <= 1'b0;
            st         <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
